// File: rtl/rx_packet_checker.sv
// Receive-side frame checker for the TX packet generator format: index/pattern/keep/length/tuser
// compare per beat, with saturating good/bad counters and cause flags for debug readout.
module rx_packet_checker #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   m00_axis_aclk,
    input  logic                   reset,
    input  logic [63:0]            m00_axis_tdata,
    input  logic [7:0]             m00_axis_tkeep,
    input  logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tlast,
    input  logic                   m00_axis_tuser,
    input  logic                   checker_enable,
    input  logic                   clear_counters,
    input  logic [15:0]            packet_length,
    input  logic [47:0]            expected_pattern,
    output logic                   locked,
    output logic                   packet_done,
    output logic                   packet_ok,
    output logic [COUNT_WIDTH-1:0] good_count,
    output logic [COUNT_WIDTH-1:0] bad_count,
    output logic [4:0]             sticky_cause,
    output logic [4:0]             last_bad_cause
);

    localparam int unsigned IDX_W   = 16;
    localparam int unsigned CAUSE_W = 5;
    localparam int unsigned C_DATA  = 0;
    localparam int unsigned C_INDEX = 1;
    localparam int unsigned C_KEEP  = 2;
    localparam int unsigned C_LEN   = 3;
    localparam int unsigned C_USER  = 4;

    typedef enum logic {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       exp_idx_q, exp_idx_d;
    logic [CAUSE_W-1:0]     acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] good_q, good_d;
    logic [COUNT_WIDTH-1:0] bad_q, bad_d;
    logic [CAUSE_W-1:0]     sticky_q, sticky_d;
    logic [CAUSE_W-1:0]     last_bad_q, last_bad_d;
    logic                   done_q, done_d;
    logic                   ok_q, ok_d;

    logic [CAUSE_W-1:0]     beat_cause;
    logic [CAUSE_W-1:0]     frame_cause;

    // Per-beat error causes against the expected generator format
    always_comb begin
        beat_cause          = '0;
        beat_cause[C_DATA]  = (m00_axis_tdata[63:16] != expected_pattern);
        beat_cause[C_INDEX] = (m00_axis_tdata[15:0] != exp_idx_q);
        beat_cause[C_KEEP]  = (m00_axis_tkeep != 8'hFF);
        beat_cause[C_LEN]   = m00_axis_tlast ? (exp_idx_q != packet_length)
                                             : (exp_idx_q == packet_length);
        beat_cause[C_USER]  = m00_axis_tlast & m00_axis_tuser;
        frame_cause         = acc_q | beat_cause;
    end

    always_comb begin
        state_d    = state_q;
        exp_idx_d  = exp_idx_q;
        acc_d      = acc_q;
        good_d     = good_q;
        bad_d      = bad_q;
        sticky_d   = sticky_q;
        last_bad_d = last_bad_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;

        if (!checker_enable) begin
            state_d   = SYNC;
            exp_idx_d = '0;
            acc_d     = '0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (m00_axis_tvalid && m00_axis_tlast) begin
                        state_d   = CHECK;
                        exp_idx_d = '0;
                        acc_d     = '0;
                    end
                end
                CHECK: begin
                    if (m00_axis_tvalid) begin
                        if (!m00_axis_tlast) begin
                            acc_d     = frame_cause;
                            exp_idx_d = exp_idx_q + IDX_W'(1);
                        end else begin
                            done_d    = 1'b1;
                            ok_d      = (frame_cause == '0);
                            exp_idx_d = '0;
                            acc_d     = '0;
                            sticky_d  = sticky_q | frame_cause;
                            if (frame_cause == '0) begin
                                if (good_q != '1) good_d = good_q + COUNT_WIDTH'(1);
                            end else begin
                                if (bad_q != '1) bad_d = bad_q + COUNT_WIDTH'(1);
                                last_bad_d = frame_cause;
                            end
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        // Clear wins over a same-cycle completion; the done pulse still goes out
        if (clear_counters) begin
            good_d     = '0;
            bad_d      = '0;
            sticky_d   = '0;
            last_bad_d = '0;
        end
    end

    always_ff @(posedge m00_axis_aclk or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            exp_idx_q  <= '0;
            acc_q      <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            sticky_q   <= '0;
            last_bad_q <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_idx_q  <= exp_idx_d;
            acc_q      <= acc_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            sticky_q   <= sticky_d;
            last_bad_q <= last_bad_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
        end
    end

    assign locked         = (state_q == CHECK);
    assign packet_done    = done_q;
    assign packet_ok      = ok_q;
    assign good_count     = good_q;
    assign bad_count      = bad_q;
    assign sticky_cause   = sticky_q;
    assign last_bad_cause = last_bad_q;

endmodule

// File: tb/tb_rx_packet_checker.sv
// Scoreboard bench for rx_packet_checker: directed frames push expected per-frame results,
// a negedge monitor pops and compares on every packet_done.
module tb_rx_packet_checker;

    localparam int unsigned CW = 4;
    localparam logic [47:0] PAT = 48'hA5A5_0000_1234;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;
    logic          tvalid;
    logic          tlast;
    logic          tuser;
    logic          checker_enable;
    logic          clear_counters;
    logic [15:0]   packet_length;
    logic [47:0]   expected_pattern;
    logic          locked;
    logic          packet_done;
    logic          packet_ok;
    logic [CW-1:0] good_count;
    logic [CW-1:0] bad_count;
    logic [4:0]    sticky_cause;
    logic [4:0]    last_bad_cause;

    int checks = 0;
    int errors = 0;

    // {ok, good, bad, sticky, last_bad}
    logic [18:0] sb_q[$];

    logic          m_locked;
    logic [CW-1:0] m_good, m_bad;
    logic [4:0]    m_sticky, m_last_bad;

    rx_packet_checker #(.COUNT_WIDTH(CW)) dut (
        .m00_axis_aclk   (clk),
        .reset           (reset),
        .m00_axis_tdata  (tdata),
        .m00_axis_tkeep  (tkeep),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tlast  (tlast),
        .m00_axis_tuser  (tuser),
        .checker_enable  (checker_enable),
        .clear_counters  (clear_counters),
        .packet_length   (packet_length),
        .expected_pattern(expected_pattern),
        .locked          (locked),
        .packet_done     (packet_done),
        .packet_ok       (packet_ok),
        .good_count      (good_count),
        .bad_count       (bad_count),
        .sticky_cause    (sticky_cause),
        .last_bad_cause  (last_bad_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every packet_done cycle must match the oldest expected frame result
    always @(negedge clk) begin
        if (!reset && packet_done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got packet_done=1 expected no pulse");
            end else begin
                logic [18:0] exp_v;
                logic [18:0] act_v;
                exp_v = sb_q.pop_front();
                act_v = {packet_ok, good_count, bad_count, sticky_cause, last_bad_cause};
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb_frame: got %05h expected %05h", act_v, exp_v);
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] idx, input logic [7:0] keep,
                             input logic last, input logic user);
        tdata  = {PAT, idx};
        tkeep  = keep;
        tvalid = 1'b1;
        tlast  = last;
        tuser  = user;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // exp_cause is the hand-computed cause vector for the frame
    task automatic send_frame(input int nbeats, input int bad_beat, input logic [15:0] bad_val,
                              input logic [7:0] last_keep, input logic last_user,
                              input logic clr, input logic [4:0] exp_cause);
        logic ok;
        for (int i = 0; i < nbeats; i++) begin
            logic lst;
            lst = (i == nbeats - 1);
            clear_counters = lst ? clr : 1'b0;
            send_beat((i == bad_beat) ? bad_val : 16'(i), lst ? last_keep : 8'hFF,
                      lst, lst ? last_user : 1'b0);
        end
        clear_counters = 1'b0;
        if (checker_enable) begin
            if (m_locked) begin
                ok = (exp_cause == 5'd0);
                if (clr) begin
                    m_good = '0; m_bad = '0; m_sticky = '0; m_last_bad = '0;
                end else begin
                    if (ok) begin
                        if (m_good != 4'hF) m_good = m_good + 4'd1;
                    end else begin
                        if (m_bad != 4'hF) m_bad = m_bad + 4'd1;
                        m_last_bad = exp_cause;
                    end
                    m_sticky = m_sticky | exp_cause;
                end
                sb_q.push_back({ok, m_good, m_bad, m_sticky, m_last_bad});
            end else begin
                m_locked = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'(m_locked));
        check({tag, "_good"}, 32'(good_count), 32'(m_good));
        check({tag, "_bad"}, 32'(bad_count), 32'(m_bad));
        check({tag, "_sticky"}, 32'(sticky_cause), 32'(m_sticky));
        check({tag, "_last_bad"}, 32'(last_bad_cause), 32'(m_last_bad));
    endtask

    initial begin
        reset = 1'b1; tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        checker_enable = 1'b1; clear_counters = 1'b0;
        packet_length = 16'd3; expected_pattern = PAT;
        m_locked = 1'b0; m_good = '0; m_bad = '0; m_sticky = '0; m_last_bad = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_done", 32'(packet_done), 32'd0);
        check("reset_ok", 32'(packet_ok), 32'd0);
        reset = 1'b0;
        idle(1);

        // Alignment partial frame, then 10 good frames back-to-back
        send_frame(2, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        for (int f = 0; f < 10; f++) send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        idle(1);
        check_all("t1");
        check("t1_good10", 32'(good_count), 32'd10);

        // Index error on beat 2
        send_frame(4, 2, 16'd5, 8'hFF, 1'b0, 1'b0, 5'b00010);
        send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        idle(1);
        check_all("t2");
        check("t2_last_bad", 32'(last_bad_cause), 32'h02);

        // Short and long frames, then a good one re-aligned at index 0
        send_frame(3, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b01000);
        send_frame(6, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b01000);
        send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        idle(1);
        check_all("t3");

        // tuser and partial keep on the last beat
        send_frame(4, -1, 16'd0, 8'h0F, 1'b1, 1'b0, 5'b10100);
        idle(2);
        check_all("t4");
        check("t4_last_bad", 32'(last_bad_cause), 32'h14);
        check("t4_sticky", 32'(sticky_cause), 32'h1E);

        // Standalone clear, saturate good_count, then clear on a tlast beat
        clear_counters = 1'b1;
        idle(1);
        clear_counters = 1'b0;
        m_good = '0; m_bad = '0; m_sticky = '0; m_last_bad = '0;
        check_all("t5_clr");
        for (int f = 0; f < 17; f++) send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        idle(1);
        check("t5_sat", 32'(good_count), 32'hF);
        send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b1, 5'b00000);
        idle(1);
        check_all("t5_clr_last");

        // Enable drop mid-frame: lock lost next cycle, counters hold, rest of frame ignored
        send_frame(4, -1, 16'd0, 8'h0F, 1'b0, 1'b0, 5'b00100);
        send_beat(16'd0, 8'hFF, 1'b0, 1'b0);
        send_beat(16'd1, 8'hFF, 1'b0, 1'b0);
        checker_enable = 1'b0;
        send_beat(16'd2, 8'hFF, 1'b0, 1'b0);
        m_locked = 1'b0;
        check_all("t6_drop");
        send_beat(16'd3, 8'hFF, 1'b1, 1'b0);
        checker_enable = 1'b1;
        idle(2);
        check_all("t6_reen");

        // Resync, then async reset mid-frame
        send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        check("t6_relock", 32'(locked), 32'd1);
        send_beat(16'd0, 8'hFF, 1'b0, 1'b0);
        send_beat(16'd1, 8'hFF, 1'b0, 1'b0);
        tvalid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        m_locked = 1'b0; m_good = '0; m_bad = '0; m_sticky = '0; m_last_bad = '0;
        check_all("t6_rst");
        check("t6_rst_done", 32'(packet_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        idle(1);
        check("t6_nocount", 32'(good_count), 32'd0);
        send_frame(4, -1, 16'd0, 8'hFF, 1'b0, 1'b0, 5'b00000);
        idle(2);
        check_all("t6_final");
        check("t6_good1", 32'(good_count), 32'd1);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_packet_checker.md
# rx_packet_checker

Receive-side counterpart of the example design's TX packet generator. It sits on the Ethernet core's RX AXI-Stream output, and the core has no backpressure on that output. The block checks every received frame against the generator's format:
- lower 16 bits are a beat index running 0..packet_length;
- upper 48 bits are a constant pattern;
- all bytes are valid;
- tlast is on index packet_length.

It keeps saturating good/bad frame counters and error-cause flags for VIO/ILA readout.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of good/bad frame counters (saturating)

Ports:
- m00_axis_aclk  input  1  RX stream clock; the only clock
- reset  input  1  asynchronous, active-high
- m00_axis_tdata  input  64  received beat data
- m00_axis_tkeep  input  8  byte enables
- m00_axis_tvalid  input  1  beat valid (no tready; every valid beat is consumed)
- m00_axis_tlast  input  1  last beat of frame
- m00_axis_tuser  input  1  frame error from core, meaningful on the tlast beat only
- checker_enable  input  1  0 forces SYNC and freezes counters
- clear_counters  input  1  synchronous clear of counters and sticky flags
- packet_length  input  16  index of the last beat (frame = packet_length+1 beats)
- expected_pattern  input  48  expected tdata[63:16]
- locked  output  1  state is CHECK
- packet_done  output  1  1-cycle pulse after each checked tlast beat
- packet_ok  output  1  valid with packet_done; frame had no errors
- good_count  output  COUNT_WIDTH  error-free frames
- bad_count  output  COUNT_WIDTH  errored frames
- sticky_cause  output  5  OR of all causes since clear: {USER, LEN, KEEP, INDEX, DATA} = bits [4:0]
- last_bad_cause  output  5  cause vector of most recent bad frame

## Operation
- States: SYNC, CHECK. Reset, or checker_enable=0, gives SYNC.
- SYNC:
  - valid beats are discarded, with no compare and no counting;
  - valid and tlast: go to CHECK, set expected_index=0, clear the per-frame error accumulator.
- CHECK, each valid beat, cause bits are set as follows:
  - DATA: tdata[63:16] != expected_pattern;
  - INDEX: tdata[15:0] != expected_index;
  - KEEP: tkeep != 8'hFF;
  - LEN: (tlast and expected_index != packet_length) or (!tlast and expected_index == packet_length);
  - USER: tlast and tuser.
- Non-last beat:
  - OR the causes into the accumulator;
  - expected_index += 1, wrapping 16'hFFFF to 0;
  - the frame continues until tlast, and the LEN flag stays set.
- Last beat:
  - frame_cause = accumulator | this beat's causes;
  - frame_cause == 0: good_count += 1;
  - otherwise: bad_count += 1 and last_bad_cause = frame_cause;
  - sticky_cause |= frame_cause;
  - expected_index = 0 and the accumulator is cleared;
  - stay in CHECK. INDEX/DATA errors never drop lock.
- Counters saturate at all-ones and do not wrap.
- clear_counters:
  - zeroes good_count, bad_count, sticky_cause, last_bad_cause;
  - takes priority over a same-cycle frame completion, which is not counted;
  - packet_done still pulses;
  - state, expected_index and accumulator are unaffected.
- checker_enable falling mid-frame:
  - the partial frame is abandoned and not counted;
  - state is SYNC next cycle;
  - counters hold.
- packet_length / expected_pattern are assumed static per test. A change takes effect on the next compared beat.

## Timing
- Reset values: locked=0, packet_done=0, packet_ok=0, good_count=0, bad_count=0, sticky_cause=0, last_bad_cause=0. Internally state=SYNC, expected_index=0, accumulator=0.
- Compare is registered. On a tlast beat at cycle N:
  - packet_done, packet_ok, counters, sticky_cause and last_bad_cause update at N+1;
  - packet_done is high for exactly one cycle.
- SYNC to CHECK: locked=1 the cycle after the aligning tlast beat. The next valid beat is compared as index 0.
- Back-to-back beats are supported: tvalid high every cycle, tlast on consecutive frames, full rate, no bubbles needed.
- tvalid=0 cycles: all state holds.
- Asynchronous reset mid-frame: all outputs return to reset values immediately, and the block resyncs on the next tlast.

## Test plan
- Reset, enable=1, packet_length=3, pattern=48'hA5A5_0000_1234. Send a 2-beat partial frame with tlast, then 10 correct 4-beat frames back-to-back. Required: first frame not counted, locked=1, good_count=10, bad_count=0, sticky_cause=0.
- Locked, packet_length=3. Send frame with beat 2 tdata[15:0]=5. Required: bad_count+1, last_bad_cause=5'b00010, next correct frame counts good.
- Locked. Send frame with tlast at index 2 (3 beats), then one with tlast at index 5 (6 beats). Required: two bad frames, LEN bit set in each. The following 4-beat frame is good and starts at index 0.
- Locked. Send correct frame but tuser=1 and tkeep=8'h0F on the last beat. Required: last_bad_cause=5'b10100, packet_done pulse with packet_ok=0 one cycle after tlast.
- Preload good_count to saturation (COUNT_WIDTH=4, 16+ good frames). Required: holds 4'hF. Assert clear_counters on a tlast cycle. Required: counters 0, that frame not counted, packet_done still pulses.
- Drop checker_enable mid-frame, then assert async reset mid-frame. Required: counters hold, locked=0 next cycle. After reset all outputs are 0, and no counting until the first tlast is seen after re-enable.
